muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit: executes the alucontrol codes MULT, MULTU, DIV and DIVU.
//  Owns the HI/LO register pair read by mfhi/mflo.
//  Sits beside the single-cycle ALU in EX. The hazard unit stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width; iteration count equals WIDTH
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      EX holds a mult/div instruction this cycle
//  alucontrol  in   5      10011 MULT, 10101 MULTU, 10110 DIV, 10111 DIVU; other codes ignored
//  srca        in   WIDTH  rs: multiplicand / dividend
//  srcb        in   WIDTH  rt: multiplier / divisor
//  flush       in   1      abort in-flight op, HI/LO untouched
//  busy        out  1      op in flight (state != IDLE)
//  done        out  1      1-cycle pulse: HI/LO just updated
//  hi          out  WIDTH  HI register
//  lo          out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0; aborts any op mid-flight.
//  Accept: in IDLE with start=1 and a valid code, latch operands, op and result sign flags.
//    Signed ops latch |srca| and |srcb|. Next state CALC, counter=WIDTH-1.
//  start in CALC/FIX, or start with any other code: ignored, no state change.
//  CALC: one radix-2 step per cycle, WIDTH cycles; counter decrements; leave at counter==0 -> FIX.
//    mult: shift-add into a 2*WIDTH accumulator.
//    div: restoring, with one shared (WIDTH+1)-bit subtractor.
//  FIX (1 cycle): apply sign correction and write hi/lo; done=1 on the next cycle; state -> IDLE.
//  Latency: hi/lo hold the new value WIDTH+2 edges after the accept edge; busy=1 for WIDTH+1 cycles.
//  Back-to-back: start may be accepted in the same cycle done=1 (state is IDLE then).
//  MULT/MULTU: {hi,lo} = full 2*WIDTH product. MULT negates the product when the operand signs differ.
//  DIV/DIVU: lo = quotient, hi = remainder.
//    Quotient truncates toward zero; remainder takes the dividend's sign.
//  Divide by zero, signed or unsigned: hi=srca, lo=all-ones. No sign fixup, no trap.
//  DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wraps naturally, no exception).
//  flush=1 in CALC/FIX: state -> IDLE next edge; hi/lo keep their old values; no done pulse.
//    flush in IDLE is a no-op; flush has priority over start in the same cycle.
//  hi/lo change only on reset, the FIX writeback or an MTHI/MTLO write; reads are combinational.
// CONFIGURATION
//  MULDIV_MTHILO_EN defined: adds ports hi_we in 1, lo_we in 1, wdata in WIDTH.
//    In IDLE, hi_we/lo_we write wdata into hi/lo at the edge. Both may assert together.
//    While busy: ignored. Same-cycle write and accept: write lands first, then the op starts.
//  Undefined: ports absent, hi/lo writable only by mult/div results.
// STRUCTURE
//  Shared package mips_pkg holds:
//    localparams ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU (5-bit alucontrol codes, shared with aludec);
//    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} muldiv_state_t.
//  No sub-module: one FSM plus one shared add/sub datapath, kept flat.
// TESTING
//  MULTU ffffffff*ffffffff -> after 34 edges hi=fffffffe lo=00000001, done one cycle, busy 33 cycles.
//  MULT -3*7 -> hi=ffffffff lo=ffffffeb; DIV -7/2 -> lo=fffffffd hi=ffffffff.
//  DIVU 100/7 -> lo=14 hi=2; DIVU 5/0 -> hi=5 lo=ffffffff; DIV 80000000/ffffffff -> lo=80000000 hi=0.
//  MULT 6*7 started, flush at cycle 10 -> busy drops next edge, hi/lo unchanged, no done.
//  start while busy, and start with alucontrol=00010 -> ignored; reset at cycle 20 -> hi=lo=0, IDLE.
//  MULDIV_MTHILO_EN: hi_we with wdata=cafef00d in IDLE -> hi=cafef00d; same write while busy -> ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: alucontrol codes for the multiply/divide unit and its state type.
// Used by aludec and muldiv_unit.
package mips_pkg;

  localparam logic [4:0] ALU_MULT  = 5'b10011;
  localparam logic [4:0] ALU_MULTU = 5'b10101;
  localparam logic [4:0] ALU_DIV   = 5'b10110;
  localparam logic [4:0] ALU_DIVU  = 5'b10111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } muldiv_state_t;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_DIV)  || (code == ALU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage bus between the pipeline and the multiply/divide unit.
// With MULDIV_MTHILO_EN defined it also carries the MTHI/MTLO write port.
interface muldiv_unit_if #(parameter int WIDTH = 32);

  logic             start;
  logic [4:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULDIV_MTHILO_EN
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;

  modport master (
    output start, alucontrol, srca, srcb, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alucontrol, srca, srcb, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
`else
  modport master (
    output start, alucontrol, srca, srcb, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alucontrol, srca, srcb, flush,
    output busy, done, hi, lo
  );
`endif

endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; radix-2, WIDTH steps plus one fixup cycle.
// Optional MTHI/MTLO write port enabled by defining MULDIV_MTHILO_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  import mips_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  logic               sgn_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               accept;

  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign sgn_op = is_signed_op(bus.alucontrol);
  assign abs_a  = (sgn_op && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
  assign abs_b  = (sgn_op && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
  assign accept = bus.start && !bus.flush && is_muldiv(bus.alucontrol);

  // One shared adder: multiply adds the multiplicand into the upper half,
  // divide subtracts the divisor from the shifted partial remainder (carry = no borrow).
  assign add_a   = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign add_b   = is_div ? ~{1'b0, opb} : {1'b0, opb};
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      if (add_sum[WIDTH+1])
        acc_step = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
      else
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Divide by zero leaves the quotient all-ones; the remainder fixup then restores srca exactly.
  assign prod_fix = neg_main ? -acc : acc;
  assign quo_fix  = (neg_main && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        MD_IDLE: begin
`ifdef MULDIV_MTHILO_EN
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
`endif
          if (accept) begin
            state    <= MD_CALC;
            cnt      <= CW'(WIDTH-1);
            is_div   <= is_div_op(bus.alucontrol);
            neg_main <= sgn_op && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            if (is_div_op(bus.alucontrol)) begin
              acc      <= {{WIDTH{1'b0}}, abs_a};
              opb      <= abs_b;
              neg_rem  <= sgn_op && bus.srca[WIDTH-1];
              div_zero <= (bus.srcb == '0);
            end else begin
              acc      <= {{WIDTH{1'b0}}, abs_b};
              opb      <= abs_a;
              neg_rem  <= 1'b0;
              div_zero <= 1'b0;
            end
          end
        end
        MD_CALC: begin
          if (bus.flush) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end else begin
              hi_r <= prod_fix[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != MD_IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
// Exercises the MTHI/MTLO port only when MULDIV_MTHILO_EN is defined.
module tb_muldiv_unit;

  import mips_pkg::*;

  logic clk;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference results straight from 64-bit integer arithmetic.
  function automatic void refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    eh = '0;
    el = '0;
    case (op)
      ALU_MULTU: begin
        p  = {32'b0, a} * {32'b0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      ALU_MULT: begin
        p  = sa * sb;
        eh = p[63:32];
        el = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hffffffff;
        end else if (op == ALU_DIVU) begin
          el = a / b;
          eh = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          el = q[31:0];
          eh = r[31:0];
        end
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with start dropped.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.srca  = $urandom;
    bus.srcb  = $urandom;
  endtask

  task automatic runOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit chain, input int pokeAt);
    logic [31:0] eh, el;
    int edges, busyCount;
    refModel(op, a, b, eh, el);
    applyStimulus(op, a, b);
    edges     = 1;
    busyCount = 0;
    while (bus.done !== 1'b1 && edges < 60) begin
      if (bus.busy === 1'b1) busyCount++;
      bus.start      = (edges == pokeAt);
      bus.alucontrol = ALU_DIVU;
      bus.srca       = $urandom;
      bus.srcb       = $urandom;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput({tag, "/latency"}, 32'(edges), 32'd34);
    checkOutput({tag, "/busycycles"}, 32'(busyCount), 32'd33);
    checkOutput({tag, "/busyoff"}, {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, "/hi"}, bus.hi, eh);
    checkOutput({tag, "/lo"}, bus.lo, el);
    lastHi = eh;
    lastLo = el;
    if (!chain) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "/donepulse"}, {31'b0, bus.done}, 32'd0);
    end
  endtask

  task automatic countDone(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
  endtask

  initial begin
    logic [4:0] codes [4];
    logic [4:0] op;
    logic [31:0] a, b;
    int seen;

    codes = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.alucontrol = '0;
    bus.srca       = '0;
    bus.srcb       = '0;
`ifdef MULDIV_MTHILO_EN
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset/hi", bus.hi, 32'd0);
    checkOutput("reset/lo", bus.lo, 32'd0);
    checkOutput("reset/busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset/done", {31'b0, bus.done}, 32'd0);

    runOp(ALU_MULTU, 32'hffffffff, 32'hffffffff, "multu_max", 1'b0, 0);
    runOp(ALU_MULT, -32'sd3, 32'd7, "mult_neg", 1'b0, 0);
    runOp(ALU_DIV, -32'sd7, 32'd2, "div_neg", 1'b0, 0);
    runOp(ALU_DIVU, 32'd100, 32'd7, "divu", 1'b0, 0);
    runOp(ALU_DIVU, 32'd5, 32'd0, "divu_zero", 1'b0, 0);
    runOp(ALU_DIV, -32'sd5, 32'd0, "div_zero", 1'b0, 0);
    runOp(ALU_DIV, 32'h80000000, 32'hffffffff, "div_ovf", 1'b0, 0);
    runOp(ALU_DIV, 32'd9, -32'sd4, "div_negdiv", 1'b0, 0);

    // done cycle doubles as the accept cycle of the next op
    runOp(ALU_MULT, 32'h12345678, 32'h9abcdef0, "b2b_first", 1'b1, 0);
    runOp(ALU_DIVU, 32'hdeadbeef, 32'd1000, "b2b_second", 1'b0, 0);

    runOp(ALU_MULTU, 32'd1234, 32'd5678, "poke_calc", 1'b0, 5);
    runOp(ALU_MULT, 32'hffff0000, 32'h00010001, "poke_fix", 1'b0, 33);

    bus.start      = 1'b1;
    bus.alucontrol = 5'b00010;
    bus.srca       = 32'd11;
    bus.srcb       = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("badcode/busy", {31'b0, bus.busy}, 32'd0);
    countDone(5, seen);
    checkOutput("badcode/nodone", 32'(seen), 32'd0);
    checkOutput("badcode/hi", bus.hi, lastHi);

    bus.flush = 1'b1;
    applyStimulus(ALU_MULT, 32'd6, 32'd7);
    bus.flush = 1'b0;
    checkOutput("flushstart/busy", {31'b0, bus.busy}, 32'd0);

    applyStimulus(ALU_MULT, 32'd6, 32'd7);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush/busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("flush/hi", bus.hi, lastHi);
    checkOutput("flush/lo", bus.lo, lastLo);
    countDone(40, seen);
    checkOutput("flush/nodone", 32'(seen), 32'd0);
    checkOutput("flush/lo_after", bus.lo, lastLo);

    for (int i = 0; i < 16; i++) begin
      op = codes[$urandom_range(0, 3)];
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      runOp(op, a, b, $sformatf("rand%0d", i), 1'b0, 0);
    end

`ifdef MULDIV_MTHILO_EN
    bus.hi_we = 1'b1;
    bus.wdata = 32'hcafef00d;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b0;
    checkOutput("mthi/hi", bus.hi, 32'hcafef00d);
    checkOutput("mthi/lo", bus.lo, lastLo);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h12345678;
    applyStimulus(ALU_MULTU, 32'd3, 32'd5);
    bus.lo_we = 1'b0;
    checkOutput("mtlo_accept/lo", bus.lo, 32'h12345678);
    checkOutput("mtlo_accept/busy", {31'b0, bus.busy}, 32'd1);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hcafef00d ^ 32'hffffffff;
    @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b0;
    checkOutput("mthi_busy/hi", bus.hi, 32'hcafef00d);
    seen = 0;
    while (bus.done !== 1'b1 && seen < 60) begin
      @(posedge clk);
      @(negedge clk);
      seen++;
    end
    checkOutput("mthilo_op/hi", bus.hi, 32'd0);
    checkOutput("mthilo_op/lo", bus.lo, 32'd15);
    lastHi = 32'd0;
    lastLo = 32'd15;
`endif

    applyStimulus(ALU_MULTU, 32'hffffffff, 32'h7);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset/busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("midreset/hi", bus.hi, 32'd0);
    checkOutput("midreset/lo", bus.lo, 32'd0);
    countDone(40, seen);
    checkOutput("midreset/nodone", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
